// File: rtl/sync_fifo_8bit.sv
// Single-clock 8x8 FIFO with registered read data, occupancy count and full/empty flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add registered overflow/underflow pulse outputs.
module sync_fifo_8bit #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 4
) (
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_WIDTH-1:0]  count,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  write,
    input  logic                  read,
    input  logic                  clk,
    input  logic                  rst
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wp;
    logic [PTR_WIDTH-1:0]  rp;
    logic                  wr_ok;
    logic                  rd_ok;

    // A simultaneous read frees a slot, so a write into a full FIFO still succeeds.
    assign wr_ok = write && (!full || read);
    assign rd_ok = read && !empty;

    assign full  = (count == CNT_WIDTH'(DEPTH));
    assign empty = (count == '0);

    // Storage is deliberately left uncleared by reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wp] <= d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            d_out <= '0;
        end else begin
            if (wr_ok) begin
                wp <= wp + PTR_WIDTH'(1);
            end
            if (rd_ok) begin
                rp    <= rp + PTR_WIDTH'(1);
                d_out <= mem[rp];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= write && !wr_ok;
            underflow <= read && !rd_ok;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_8bit.sv
// Self-checking bench for sync_fifo_8bit: random and directed traffic against a queue-based model.
// Honours SYNC_FIFO_ERR_FLAGS_EN to also check the overflow/underflow pulses.
module tb_sync_fifo_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] d_in;
    logic       write;
    logic       read;
    logic [7:0] d_out;
    logic       full;
    logic       empty;
    logic [3:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int checks;
    int failures;

    logic [7:0] model_q [$];
    logic [7:0] exp_dout;
    logic       exp_ovf;
    logic       exp_unf;

    sync_fifo_8bit dut (
        .d_out     (d_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .d_in      (d_in),
        .write     (write),
        .read      (read),
        .clk       (clk),
        .rst       (rst)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of stimulus, advances the reference queue, and leaves the bench 1ns past the edge.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic rs);
        logic m_full;
        logic m_wr;
        logic m_rd;
        write = w;
        read  = r;
        d_in  = d;
        rst   = rs;
        @(posedge clk);
        if (rs) begin
            model_q.delete();
            exp_dout = 8'h00;
            exp_ovf  = 1'b0;
            exp_unf  = 1'b0;
        end else begin
            m_full = (model_q.size() == 8);
            m_wr   = w && (!m_full || r);
            m_rd   = r && (model_q.size() != 0);
            if (m_rd) exp_dout = model_q.pop_front();
            if (m_wr) model_q.push_back(d);
            exp_ovf = w && !m_wr;
            exp_unf = r && !m_rd;
        end
        #1;
        write = 1'b0;
        read  = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
        end
        cycle(1'b1, 1'b1, 8'hA5, 1'b1);
        checks++;
        if (count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_count got=%0d want=0", count);
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got empty=%b full=%b want empty=1 full=0", empty, full);
        end
        checks++;
        if (d_out !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_dout got=%h want=00", d_out);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_errflags got ovf=%b unf=%b want 0 0", overflow, underflow);
        end
`endif
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, 8'(i * 8'h11), 1'b0);
            checks++;
            if (count !== 4'(i) || empty !== 1'b0 || full !== (i == 8)) begin
                failures++;
                $display("[TB] FAIL fill_%0d got count=%0d full=%b empty=%b want count=%0d full=%b empty=0",
                         i, count, full, empty, i, (i == 8));
            end
        end
        cycle(1'b1, 1'b0, 8'hFF, 1'b0);
        checks++;
        if (count !== 4'd8 || full !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fill_overwrite got count=%0d full=%b want count=8 full=1", count, full);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overflow_pulse got=%b want=1", overflow);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overflow_clear got=%b want=0", overflow);
        end
`endif
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            checks++;
            if (d_out !== 8'(i * 8'h11) || count !== 4'(8 - i)) begin
                failures++;
                $display("[TB] FAIL drain_%0d got d_out=%h count=%0d want d_out=%h count=%0d",
                         i, d_out, count, 8'(i * 8'h11), 8 - i);
            end
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_empty got empty=%b full=%b want 1 0", empty, full);
        end
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (d_out !== 8'h88 || count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL drain_extra got d_out=%h count=%0d want 88 0", d_out, count);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL underflow_pulse got=%b want=1", underflow);
        end
`endif
    endtask

    task automatic test_simultaneous();
        logic [7:0] held;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
        end
        cycle(1'b1, 1'b1, 8'hC3, 1'b0);
        checks++;
        if (count !== 4'd8 || full !== 1'b1 || d_out !== exp_dout) begin
            failures++;
            $display("[TB] FAIL rw_full got count=%0d full=%b d_out=%h want 8 1 %h",
                     count, full, d_out, exp_dout);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
        end
        checks++;
        if (d_out !== 8'hC3 || empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rw_full_tail got d_out=%h empty=%b want c3 1", d_out, empty);
        end
        held = exp_dout;
        cycle(1'b1, 1'b1, 8'h5A, 1'b0);
        checks++;
        if (count !== 4'd1 || d_out !== held) begin
            failures++;
            $display("[TB] FAIL rw_empty got count=%0d d_out=%h want 1 %h", count, d_out, held);
        end
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (d_out !== 8'h5A || count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL rw_empty_read got d_out=%h count=%0d want 5a 0", d_out, count);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, 1'($urandom), 8'($urandom), 1'b0);
            checks++;
            if (d_out !== exp_dout || count !== 4'(model_q.size()) ||
                full !== (model_q.size() == 8) || empty !== (model_q.size() == 0)) begin
                failures++;
                $display("[TB] FAIL wrap_%0d got d_out=%h count=%0d want d_out=%h count=%0d",
                         i, d_out, count, exp_dout, model_q.size());
            end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            checks++;
            if (overflow !== exp_ovf || underflow !== exp_unf) begin
                failures++;
                $display("[TB] FAIL wrap_err_%0d got ovf=%b unf=%b want %b %b",
                         i, overflow, underflow, exp_ovf, exp_unf);
            end
`endif
        end
        while (model_q.size() != 0) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            checks++;
            if (d_out !== exp_dout) begin
                failures++;
                $display("[TB] FAIL wrap_drain got d_out=%h want %h", d_out, exp_dout);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
        end
        checks++;
        if (count !== 4'd5) begin
            failures++;
            $display("[TB] FAIL midrst_pre got count=%0d want 5", count);
        end
        cycle(1'b1, 1'b1, 8'hEE, 1'b1);
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || d_out !== 8'h00) begin
            failures++;
            $display("[TB] FAIL midrst got count=%0d empty=%b d_out=%h want 0 1 00", count, empty, d_out);
        end
        cycle(1'b1, 1'b0, 8'h3C, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (d_out !== 8'h3C || count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL midrst_after got d_out=%h count=%0d want 3c 0", d_out, count);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_dout = 8'h00;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        write    = 1'b0;
        read     = 1'b0;
        d_in     = 8'h00;
        rst      = 1'b1;
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
